// File: rtl/pkt_ring_sched.sv
// Packet ring scheduler: turns packet descriptors into one or two write-controller
// commands that place each packet into a circular byte ring, splitting at the ring end.
module pkt_ring_sched (
    input  logic        clk,
    input  logic        reset,
    input  logic        desc_valid,
    input  logic [15:0] desc_len,
    output logic        desc_ready,
    input  logic [31:0] ring_base,
    input  logic [31:0] ring_size,
    input  logic [31:0] host_rd_ptr,
    input  logic        enable,
    output logic        wr_ctrl,
    output logic [31:0] control,
    output logic [31:0] pkt_begin,
    output logic [31:0] pkt_end,
    output logic [31:0] write_address,
    input  logic        wr_ctrl_rdy,
    output logic [31:0] wr_ptr,
    output logic [31:0] pkt_count,
    output logic [15:0] drop_count,
    output logic        err
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CHECK = 3'd1;
    localparam logic [2:0] SEG1  = 3'd2;
    localparam logic [2:0] GAP1  = 3'd3;
    localparam logic [2:0] SEG2  = 3'd4;
    localparam logic [2:0] GAP2  = 3'd5;

    logic [2:0]  state_reg;
    logic [2:0]  state_next;

    logic [15:0] len_reg;
    logic [16:0] rlen_reg;
    logic [31:0] tail_reg;
    logic        split_reg;

    logic        wr_ctrl_reg;
    logic [31:0] control_reg;
    logic [31:0] pkt_begin_reg;
    logic [31:0] pkt_end_reg;
    logic [31:0] write_address_reg;
    logic [31:0] wr_ptr_reg;
    logic [31:0] pkt_count_reg;
    logic [15:0] drop_count_reg;
    logic        err_reg;

    logic        accept;
    logic        seg_done;
    logic        last_gap;
    logic [31:0] rlen_ext;
    logic [31:0] used;
    logic [31:0] free_space;
    logic [31:0] tail;
    logic [32:0] wr_ptr_sum;
    logic [32:0] wr_ptr_wrap;
    logic [31:0] wr_ptr_next;
    logic        len_zero;
    logic        oversize;
    logic        no_room;
    logic        split;

    assign desc_ready = reset & enable & (state_reg == IDLE);
    assign accept     = desc_valid & desc_ready;
    assign seg_done   = wr_ctrl_reg & wr_ctrl_rdy;
    assign last_gap   = (state_reg == GAP2) | ((state_reg == GAP1) & ~split_reg);

    // Occupancy keeps one word in reserve so equal pointers always mean an empty ring.
    always_comb begin
        rlen_ext = {15'd0, rlen_reg};
        if (wr_ptr_reg >= host_rd_ptr) begin
            used = wr_ptr_reg - host_rd_ptr;
        end else begin
            used = wr_ptr_reg + ring_size - host_rd_ptr;
        end
        free_space  = ring_size - used - 32'd4;
        tail        = ring_size - wr_ptr_reg;
        len_zero    = (len_reg == 16'd0);
        oversize    = rlen_ext > (ring_size - 32'd4);
        no_room     = rlen_ext > free_space;
        split       = rlen_ext > tail;
        wr_ptr_sum  = {1'b0, wr_ptr_reg} + {16'd0, rlen_reg};
        wr_ptr_wrap = wr_ptr_sum - {1'b0, ring_size};
        if (wr_ptr_sum >= {1'b0, ring_size}) begin
            wr_ptr_next = wr_ptr_wrap[31:0];
        end else begin
            wr_ptr_next = wr_ptr_sum[31:0];
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (len_zero || oversize) begin
                    state_next = IDLE;
                end else if (!no_room) begin
                    state_next = SEG1;
                end
            end
            SEG1: begin
                if (seg_done) begin
                    state_next = GAP1;
                end
            end
            GAP1: begin
                state_next = split_reg ? SEG2 : IDLE;
            end
            SEG2: begin
                if (seg_done) begin
                    state_next = GAP2;
                end
            end
            GAP2: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg         <= IDLE;
            len_reg           <= 16'd0;
            rlen_reg          <= 17'd0;
            tail_reg          <= 32'd0;
            split_reg         <= 1'b0;
            wr_ctrl_reg       <= 1'b0;
            control_reg       <= 32'd0;
            pkt_begin_reg     <= 32'd0;
            pkt_end_reg       <= 32'd0;
            write_address_reg <= 32'd0;
            wr_ptr_reg        <= 32'd0;
            pkt_count_reg     <= 32'd0;
            drop_count_reg    <= 16'd0;
            err_reg           <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        len_reg  <= desc_len;
                        rlen_reg <= ({1'b0, desc_len} + 17'd3) & ~17'd3;
                    end
                end
                CHECK: begin
                    if (len_zero || oversize) begin
                        if (oversize && !len_zero) begin
                            err_reg <= 1'b1;
                        end
                        if (drop_count_reg != 16'hFFFF) begin
                            drop_count_reg <= drop_count_reg + 16'd1;
                        end
                    end else if (!no_room) begin
                        // Split and tail are frozen here so the second segment sees the same geometry.
                        split_reg         <= split;
                        tail_reg          <= tail;
                        wr_ctrl_reg       <= 1'b1;
                        write_address_reg <= ring_base + wr_ptr_reg;
                        pkt_begin_reg     <= 32'd0;
                        pkt_end_reg       <= split ? tail : {16'd0, len_reg};
                        control_reg       <= {14'd0, ~split, 1'b0, len_reg};
                    end
                end
                SEG1, SEG2: begin
                    if (seg_done) begin
                        wr_ctrl_reg <= 1'b0;
                    end
                end
                GAP1: begin
                    if (split_reg) begin
                        wr_ctrl_reg       <= 1'b1;
                        write_address_reg <= ring_base;
                        pkt_begin_reg     <= tail_reg;
                        pkt_end_reg       <= {16'd0, len_reg};
                        control_reg       <= {14'd0, 1'b1, 1'b1, len_reg};
                    end
                end
                default: begin
                end
            endcase
            if (last_gap) begin
                wr_ptr_reg    <= wr_ptr_next;
                pkt_count_reg <= pkt_count_reg + 32'd1;
            end
        end
    end

    assign wr_ctrl       = wr_ctrl_reg;
    assign control       = control_reg;
    assign pkt_begin     = pkt_begin_reg;
    assign pkt_end       = pkt_end_reg;
    assign write_address = write_address_reg;
    assign wr_ptr        = wr_ptr_reg;
    assign pkt_count     = pkt_count_reg;
    assign drop_count    = drop_count_reg;
    assign err           = err_reg;

endmodule

// File: tb/tb_pkt_ring_sched.sv
// Scoreboard bench for pkt_ring_sched: expected commands are queued at descriptor
// acceptance and compared when wr_ctrl rises; status is checked after each packet.
module tb_pkt_ring_sched;

    logic        clk;
    logic        reset;
    logic        desc_valid;
    logic [15:0] desc_len;
    logic        desc_ready;
    logic [31:0] ring_base;
    logic [31:0] ring_size;
    logic [31:0] host_rd_ptr;
    logic        enable;
    logic        wr_ctrl;
    logic [31:0] control;
    logic [31:0] pkt_begin;
    logic [31:0] pkt_end;
    logic [31:0] write_address;
    logic        wr_ctrl_rdy;
    logic [31:0] wr_ptr;
    logic [31:0] pkt_count;
    logic [15:0] drop_count;
    logic        err;

    pkt_ring_sched dut (
        .clk          (clk),
        .reset        (reset),
        .desc_valid   (desc_valid),
        .desc_len     (desc_len),
        .desc_ready   (desc_ready),
        .ring_base    (ring_base),
        .ring_size    (ring_size),
        .host_rd_ptr  (host_rd_ptr),
        .enable       (enable),
        .wr_ctrl      (wr_ctrl),
        .control      (control),
        .pkt_begin    (pkt_begin),
        .pkt_end      (pkt_end),
        .write_address(write_address),
        .wr_ctrl_rdy  (wr_ctrl_rdy),
        .wr_ptr       (wr_ptr),
        .pkt_count    (pkt_count),
        .drop_count   (drop_count),
        .err          (err)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] pbeg;
        logic [31:0] pend;
        logic [31:0] ctrl;
        int          lat_ref;
        bit          second;
    } cmd_t;

    cmd_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int fall_cyc = 0;
    bit wr_prev = 0;
    bit resp_en = 1;
    int rdy_cnt = 0;

    int m_wr = 0;
    int m_pkt = 0;
    int m_drop = 0;
    int m_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model of the ring: computes the command(s) for one accepted descriptor.
    task automatic push_expected(input int len, input int lat_ref);
        int   size;
        int   rlen;
        int   tail;
        cmd_t c;
        size = int'(ring_size);
        rlen = (len + 3) & ~3;
        if (len == 0) begin
            m_drop++;
        end else if (rlen > size - 4) begin
            m_drop++;
            m_err = 1;
        end else begin
            tail = size - m_wr;
            c.addr    = ring_base + 32'(m_wr);
            c.pbeg    = 32'd0;
            c.pend    = (rlen > tail) ? 32'(tail) : 32'(len);
            c.ctrl    = 32'(len) | ((rlen > tail) ? 32'd0 : 32'h20000);
            c.lat_ref = lat_ref;
            c.second  = 1'b0;
            exp_q.push_back(c);
            if (rlen > tail) begin
                c.addr    = ring_base;
                c.pbeg    = 32'(tail);
                c.pend    = 32'(len);
                c.ctrl    = 32'(len) | 32'h30000;
                c.lat_ref = -1;
                c.second  = 1'b1;
                exp_q.push_back(c);
            end
            m_wr = (m_wr + rlen) % size;
            m_pkt++;
        end
    endtask

    task automatic send_pkt(input int len, input bit chk_lat);
        int n;
        int acc;
        n = 0;
        acc = 0;
        @(negedge clk);
        desc_valid = 1'b1;
        desc_len   = len[15:0];
        while (!desc_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!desc_ready) begin
            check_val("accept_timeout", desc_ready, 1'b1);
            desc_valid = 1'b0;
        end else begin
            acc = cyc;
            push_expected(len, chk_lat ? acc : -1);
            @(negedge clk);
            desc_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!desc_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!desc_ready) check_val("idle_timeout", desc_ready, 1'b1);
    endtask

    task automatic check_status(input string tag);
        check_val({tag, "_wr_ptr"}, wr_ptr, 32'(m_wr));
        check_val({tag, "_pkt_count"}, pkt_count, 32'(m_pkt));
        check_val({tag, "_drop_count"}, {16'd0, drop_count}, 32'(m_drop));
        check_val({tag, "_err"}, {31'd0, err}, 32'(m_err));
        check_val({tag, "_outstanding"}, 32'(exp_q.size()), 32'd0);
        $display("status %s: wr_ptr=0x%08h pkt_count=%0d drop_count=%0d err=%0b",
                 tag, wr_ptr, pkt_count, drop_count, err);
    endtask

    // Write-controller model: completes each segment after a random 0..3 cycle delay.
    initial begin
        wr_ctrl_rdy = 1'b0;
        forever begin
            @(negedge clk);
            wr_ctrl_rdy = 1'b0;
            if (reset && wr_ctrl && resp_en) begin
                if (rdy_cnt == 0) begin
                    wr_ctrl_rdy = 1'b1;
                    rdy_cnt = $urandom_range(0, 3);
                end else begin
                    rdy_cnt--;
                end
            end
        end
    end

    // Command monitor: pops the scoreboard on each rising wr_ctrl and checks field stability.
    initial begin
        cmd_t        cur;
        logic [31:0] h_addr;
        logic [31:0] h_beg;
        logic [31:0] h_end;
        logic [31:0] h_ctrl;
        h_addr = 32'd0;
        h_beg  = 32'd0;
        h_end  = 32'd0;
        h_ctrl = 32'd0;
        forever begin
            @(negedge clk);
            if (reset && wr_ctrl) begin
                if (!wr_prev) begin
                    $display("cmd cycle=%0d addr=0x%08h begin=%0d end=%0d control=0x%08h",
                             cyc, write_address, pkt_begin, pkt_end, control);
                    if (exp_q.size() == 0) begin
                        check_val("spurious_cmd", {31'd0, wr_ctrl}, 32'd0);
                    end else begin
                        cur = exp_q.pop_front();
                        check_val("cmd_addr", write_address, cur.addr);
                        check_val("cmd_begin", pkt_begin, cur.pbeg);
                        check_val("cmd_end", pkt_end, cur.pend);
                        check_val("cmd_control", control, cur.ctrl);
                        if (cur.lat_ref >= 0) check_val("cmd_latency", 32'(cyc - cur.lat_ref), 32'd2);
                        if (cur.second) check_val("seg_gap", 32'(cyc - fall_cyc), 32'd1);
                    end
                    h_addr = write_address;
                    h_beg  = pkt_begin;
                    h_end  = pkt_end;
                    h_ctrl = control;
                end else begin
                    check_val("hold_addr", write_address, h_addr);
                    check_val("hold_begin", pkt_begin, h_beg);
                    check_val("hold_end", pkt_end, h_end);
                    check_val("hold_control", control, h_ctrl);
                end
            end
            if (wr_prev && !wr_ctrl) fall_cyc = cyc;
            wr_prev = wr_ctrl;
        end
    end

    initial begin
        int n;
        int hi_cnt;
        int len;

        reset       = 1'b0;
        desc_valid  = 1'b1;
        desc_len    = 16'd16;
        enable      = 1'b1;
        ring_base   = 32'h8000;
        ring_size   = 32'h100;
        host_rd_ptr = 32'd0;

        // Reset held with a descriptor presented.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_desc_ready", {31'd0, desc_ready}, 32'd0);
        check_val("rst_wr_ctrl", {31'd0, wr_ctrl}, 32'd0);
        check_val("rst_control", control, 32'd0);
        check_val("rst_pkt_begin", pkt_begin, 32'd0);
        check_val("rst_pkt_end", pkt_end, 32'd0);
        check_val("rst_write_address", write_address, 32'd0);
        check_status("reset");
        reset      = 1'b1;
        desc_valid = 1'b0;

        send_pkt(32, 1'b1);
        wait_idle();
        check_status("single");
        check_val("single_wr_ptr_abs", wr_ptr, 32'h20);

        send_pkt(30, 1'b1);
        wait_idle();
        check_status("rounding");

        @(negedge clk);
        host_rd_ptr = 32'h40;
        send_pkt(176, 1'b1);
        wait_idle();
        check_status("fill_f0");

        @(negedge clk);
        host_rd_ptr = 32'hF0;
        send_pkt(32, 1'b1);
        wait_idle();
        check_status("wrap");
        check_val("wrap_wr_ptr_abs", wr_ptr, 32'h10);

        @(negedge clk);
        host_rd_ptr = 32'h10;
        send_pkt(208, 1'b1);
        wait_idle();
        check_status("fill_e0");

        // Ring nearly full: the descriptor must stall until the host frees space.
        @(negedge clk);
        host_rd_ptr = 32'd0;
        send_pkt(32, 1'b0);
        hi_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (wr_ctrl) hi_cnt++;
        end
        check_val("stall_no_cmd", 32'(hi_cnt), 32'd0);
        host_rd_ptr = 32'h20;
        @(negedge clk);
        check_val("stall_release", {31'd0, wr_ctrl}, 32'd1);
        wait_idle();
        check_status("stall");

        send_pkt(256, 1'b0);
        wait_idle();
        send_pkt(0, 1'b0);
        wait_idle();
        check_status("invalid");
        check_val("invalid_drop_abs", {16'd0, drop_count}, 32'd2);

        // enable dropped mid-packet: the packet still finishes, nothing new is accepted.
        @(negedge clk);
        host_rd_ptr = 32'(m_wr);
        send_pkt(64, 1'b1);
        n = 0;
        while (!wr_ctrl && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val("en_cmd_seen", {31'd0, wr_ctrl}, 32'd1);
        enable = 1'b0;
        repeat (20) @(negedge clk);
        check_val("en_desc_ready", {31'd0, desc_ready}, 32'd0);
        check_status("enable_off");
        enable = 1'b1;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            host_rd_ptr = 32'(m_wr);
            len = $urandom_range(1, 240);
            send_pkt(len, 1'b1);
            wait_idle();
            check_status("random");
        end

        // Reset while a segment is outstanding.
        @(negedge clk);
        host_rd_ptr = 32'(m_wr);
        resp_en = 1'b0;
        send_pkt(16, 1'b1);
        n = 0;
        while (!wr_ctrl && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val("rstmid_cmd_seen", {31'd0, wr_ctrl}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check_val("rstmid_wr_ctrl", {31'd0, wr_ctrl}, 32'd0);
        m_wr = 0;
        m_pkt = 0;
        m_drop = 0;
        m_err = 0;
        exp_q.delete();
        check_status("rstmid");
        host_rd_ptr = 32'd0;
        reset = 1'b1;
        resp_en = 1'b1;
        hi_cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (wr_ctrl) hi_cnt++;
        end
        check_val("rstmid_no_resume", 32'(hi_cnt), 32'd0);

        send_pkt(16, 1'b1);
        wait_idle();
        check_status("post_reset");

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
